noliner_axil_regfile: RTL and testbench

AXI4-Lite slave register file that the master VIP drives at the S00_AXI port of the Exin_noliner2 IP.
- Decodes four 32-bit read/write registers (byte offsets 0x0, 0x4, 0x8, 0xC).
- Presents register contents and per-register write strobes to the downstream nonlinear core.
- Sits directly downstream of the AXI master and directly upstream of the compute datapath.

---
 rtl/noliner_axil_pkg.sv | 28 ++
 rtl/noliner_axil_wstrb_merge.sv | 22 ++
 rtl/noliner_axil_regfile.sv | 168 ++++++++++++++++
 tb/tb_noliner_axil_regfile.sv | 604 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noliner_axil_pkg.sv
// noliner_axil_pkg: shared types and constants for the AXI4-Lite register file.
// Used by the top; NOLINER_AXIL_SLVERR_EN (see top) does not change this file.
package noliner_axil_pkg;

    localparam int NUM_REGS = 4;

    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    localparam logic [3:0] REG0_OFF = 4'h0;
    localparam logic [3:0] REG1_OFF = 4'h4;
    localparam logic [3:0] REG2_OFF = 4'h8;
    localparam logic [3:0] REG3_OFF = 4'hC;

endpackage

// File: rtl/noliner_axil_wstrb_merge.sv
// noliner_axil_wstrb_merge: byte-lane merge of an old word with new write data.
// Purely combinational; a cleared strobe keeps the old byte.
import noliner_axil_pkg::*;

module noliner_axil_wstrb_merge (
    input  logic [31:0] old_val,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    // Take each new byte only where its strobe is set.
    always_comb begin
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/noliner_axil_regfile.sv
// noliner_axil_regfile: AXI4-Lite slave with four 32-bit registers for the core.
// Macro NOLINER_AXIL_SLVERR_EN: 6-bit address, SLVERR on word index >= 4.
import noliner_axil_pkg::*;

module noliner_axil_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
`ifdef NOLINER_AXIL_SLVERR_EN
    parameter int C_S_AXI_ADDR_WIDTH = 6
`else
    parameter int C_S_AXI_ADDR_WIDTH = 4
`endif
) (
    input  logic                                        ACLK,
    input  logic                                        ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
    input  logic [2:0]                                  S_AXI_AWPROT,
    input  logic                                        S_AXI_AWVALID,
    output logic                                        S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
    input  logic [3:0]                                  S_AXI_WSTRB,
    input  logic                                        S_AXI_WVALID,
    output logic                                        S_AXI_WREADY,
    output logic [1:0]                                  S_AXI_BRESP,
    output logic                                        S_AXI_BVALID,
    input  logic                                        S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
    input  logic [2:0]                                  S_AXI_ARPROT,
    input  logic                                        S_AXI_ARVALID,
    output logic                                        S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
    output logic [1:0]                                  S_AXI_RRESP,
    output logic                                        S_AXI_RVALID,
    input  logic                                        S_AXI_RREADY,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                         reg_wr_pulse
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = AW - 2;

    w_state_t                     w_state_q, w_state_d;
    r_state_t                     r_state_q, r_state_d;
    logic [IW-1:0]                aw_idx_q, aw_idx_d;
    logic [IW-1:0]                ar_idx_q, ar_idx_d;
    axi_resp_t                    bresp_q, bresp_d;
    axi_resp_t                    rresp_q, rresp_d;
    logic [DW-1:0]                rdata_q, rdata_d;
    logic [NUM_REGS-1:0][DW-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]          pulse_q, pulse_d;
    logic [DW-1:0]                merged;
    logic                         aw_hit;
    logic                         ar_hit;
    logic                         unused_ok;

`ifdef NOLINER_AXIL_SLVERR_EN
    assign aw_hit = (aw_idx_q[IW-1:2] == '0);
    assign ar_hit = (ar_idx_q[IW-1:2] == '0);
`else
    assign aw_hit = 1'b1;
    assign ar_hit = 1'b1;
`endif

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    noliner_axil_wstrb_merge u_merge (
        .old_val (regs_q[aw_idx_q[1:0]]),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .merged  (merged)
    );

    // Write path: wait for AW and W together, ack one cycle, then hold B.
    always_comb begin
        w_state_d = w_state_q;
        aw_idx_d  = aw_idx_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    aw_idx_d  = S_AXI_AWADDR[AW-1:2];
                    w_state_d = W_ACK;
                end
            end
            W_ACK: begin
                w_state_d = W_RESP;
                bresp_d   = aw_hit ? RESP_OKAY : RESP_SLVERR;
                if (aw_hit) begin
                    regs_d[aw_idx_q[1:0]]  = merged;
                    pulse_d[aw_idx_q[1:0]] = 1'b1;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path: latch address, ack one cycle, capture data, hold R.
    always_comb begin
        r_state_d = r_state_q;
        ar_idx_d  = ar_idx_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    ar_idx_d  = S_AXI_ARADDR[AW-1:2];
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                r_state_d = R_DATA;
                rdata_d   = ar_hit ? regs_q[ar_idx_q[1:0]] : '0;
                rresp_d   = ar_hit ? RESP_OKAY : RESP_SLVERR;
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and register flops; reset abandons any transaction.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_idx_q  <= '0;
            ar_idx_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            regs_q    <= '0;
            pulse_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_idx_q  <= aw_idx_d;
            ar_idx_q  <= ar_idx_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
        end
    end

    assign S_AXI_AWREADY = (w_state_q == W_ACK);
    assign S_AXI_WREADY  = (w_state_q == W_ACK);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (r_state_q == R_ADDR);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_q         = regs_q;
    assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_noliner_axil_regfile.sv
// tb_noliner_axil_regfile: randomized self-checking bench for noliner_axil_regfile.
// Reference model is a plain array of four words plus byte-mask arithmetic.
import noliner_axil_pkg::*;

module tb_noliner_axil_regfile;

`ifdef NOLINER_AXIL_SLVERR_EN
    localparam int AW = 6;
`else
    localparam int AW = 4;
`endif

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic [AW-1:0]  S_AXI_AWADDR = '0;
    logic [2:0]     S_AXI_AWPROT = '0;
    logic           S_AXI_AWVALID = 1'b0;
    logic           S_AXI_AWREADY;
    logic [31:0]    S_AXI_WDATA = '0;
    logic [3:0]     S_AXI_WSTRB = '0;
    logic           S_AXI_WVALID = 1'b0;
    logic           S_AXI_WREADY;
    logic [1:0]     S_AXI_BRESP;
    logic           S_AXI_BVALID;
    logic           S_AXI_BREADY = 1'b0;
    logic [AW-1:0]  S_AXI_ARADDR = '0;
    logic [2:0]     S_AXI_ARPROT = '0;
    logic           S_AXI_ARVALID = 1'b0;
    logic           S_AXI_ARREADY;
    logic [31:0]    S_AXI_RDATA;
    logic [1:0]     S_AXI_RRESP;
    logic           S_AXI_RVALID;
    logic           S_AXI_RREADY = 1'b0;
    logic [3:0][31:0] reg_q;
    logic [3:0]     reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [4];

    always #5 ACLK = ~ACLK;

    noliner_axil_regfile dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    // Reference rules: byte mask from strobes, word index, error range.
    function automatic logic [31:0] ref_merge(input logic [31:0] o,
                                              input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        if (s[0]) m = m | 32'h0000_00FF;
        if (s[1]) m = m | 32'h0000_FF00;
        if (s[2]) m = m | 32'h00FF_0000;
        if (s[3]) m = m | 32'hFF00_0000;
        return (o & ~m) | (d & m);
    endfunction

    function automatic int ref_idx(input logic [AW-1:0] a);
`ifdef NOLINER_AXIL_SLVERR_EN
        return int'(a) / 4;
`else
        return (int'(a) / 4) % 4;
`endif
    endfunction

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] pulse);
        bit got;
        got = 0;
        resp = 2'bxx;
        pulse = 4'bxxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b_timeout: BVALID never rose, required 1");
        end else begin
            resp = S_AXI_BRESP;
            pulse = reg_wr_pulse;
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] pulse);
        bit got;
        S_AXI_AWADDR = a;
        S_AXI_WDATA = d;
        S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL aw_timeout: AWREADY never rose, required 1");
        end
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        wait_b(resp, pulse);
    endtask

    task automatic do_read(input logic [AW-1:0] a,
                           output logic [31:0] data, output logic [1:0] resp);
        bit got;
        S_AXI_ARADDR = a;
        S_AXI_ARVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin
                got = 1;
                break;
            end
        end
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 20 && got; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin
                got = 0;
                break;
            end
        end
        checks++;
        if (got || !S_AXI_RVALID) begin
            errors++;
            $display("FAIL r_timeout: read handshake incomplete");
            data = 32'hxxxx_xxxx;
            resp = 2'bxx;
        end else begin
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hs: got %b required 00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
        end
        checks++;
        if ({S_AXI_BRESP, S_AXI_RRESP} !== 4'b0) begin
            errors++;
            $display("FAIL reset_resp: got %b required 0000", {S_AXI_BRESP, S_AXI_RRESP});
        end
        checks++;
        if (S_AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0", S_AXI_RDATA);
        end
        checks++;
        if (reg_q !== '0 || reg_wr_pulse !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs: reg_q %h pulse %b required 0", reg_q, reg_wr_pulse);
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    endtask

    task automatic test_sequential();
        logic [AW-1:0] offs [4];
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] rd;
        offs[0] = AW'(REG0_OFF);
        offs[1] = AW'(REG1_OFF);
        offs[2] = AW'(REG2_OFF);
        offs[3] = AW'(REG3_OFF);
        for (int i = 0; i < 4; i++) begin
            do_write(offs[i], 32'(i + 1), 4'hF, resp, pulse);
            mdl[i] = 32'(i + 1);
            checks++;
            if (resp !== RESP_OKAY || pulse !== 4'(1 << i)) begin
                errors++;
                $display("FAIL seq_wr%0d: resp %b pulse %b required 00 %b",
                         i, resp, pulse, 4'(1 << i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(offs[i], rd, resp);
            checks++;
            if (rd !== mdl[i] || resp !== RESP_OKAY) begin
                errors++;
                $display("FAIL seq_rd%0d: data %h resp %b required %h 00", i, rd, resp, mdl[i]);
            end
            checks++;
            if (reg_q[i] !== mdl[i]) begin
                errors++;
                $display("FAIL seq_regq%0d: got %h required %h", i, reg_q[i], mdl[i]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] rd;
        do_write(AW'(4), 32'h0000_0002, 4'hF, resp, pulse);
        mdl[1] = 32'h0000_0002;
        do_write(AW'(4), 32'hAABB_CCDD, 4'b0011, resp, pulse);
        mdl[1] = ref_merge(mdl[1], 32'hAABB_CCDD, 4'b0011);
        do_read(AW'(4), rd, resp);
        checks++;
        if (rd !== 32'h0000_CCDD || rd !== mdl[1]) begin
            errors++;
            $display("FAIL strobe: got %h required 0000ccdd", rd);
        end
    endtask

    task automatic test_wstrb_zero();
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] rd;
        do_write(AW'(8), $urandom, 4'h0, resp, pulse);
        checks++;
        if (resp !== RESP_OKAY || pulse !== 4'b0100) begin
            errors++;
            $display("FAIL wstrb0_b: resp %b pulse %b required 00 0100", resp, pulse);
        end
        do_read(AW'(8), rd, resp);
        checks++;
        if (rd !== mdl[2]) begin
            errors++;
            $display("FAIL wstrb0_rd: got %h required %h", rd, mdl[2]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [31:0] d, rd;
        logic [3:0] s, pulse, ep;
        logic [1:0] resp, er;
        int idx;
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom_range(0, (1 << AW) - 1));
            idx = ref_idx(a);
            er = (idx >= 4) ? RESP_SLVERR : RESP_OKAY;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, resp, pulse);
                ep = (idx >= 4) ? 4'h0 : 4'(1 << idx);
                if (idx < 4) mdl[idx] = ref_merge(mdl[idx], d, s);
                checks++;
                if (resp !== er || pulse !== ep) begin
                    errors++;
                    $display("FAIL rnd_wr a=%h: resp %b pulse %b required %b %b",
                             a, resp, pulse, er, ep);
                end
            end else begin
                do_read(a, rd, resp);
                checks++;
                if (resp !== er || rd !== ((idx >= 4) ? 32'h0 : mdl[idx % 4])) begin
                    errors++;
                    $display("FAIL rnd_rd a=%h: data %h resp %b required %h %b", a, rd, resp,
                             (idx >= 4) ? 32'h0 : mdl[idx % 4], er);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (reg_q[i] !== mdl[i]) begin
                errors++;
                $display("FAIL rnd_regq%0d: got %h required %h", i, reg_q[i], mdl[i]);
            end
        end
    endtask

    task automatic test_aw_early();
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] d;
        int nack;
        bit apart;
        d = $urandom;
        S_AXI_AWADDR = AW'(4);
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
                errors++;
                $display("FAIL aw_early%0d: ready %b%b required 00", i, S_AXI_AWREADY, S_AXI_WREADY);
            end
        end
        @(posedge ACLK);
        #1;
        S_AXI_WDATA = d;
        S_AXI_WSTRB = 4'hF;
        S_AXI_WVALID = 1'b1;
        nack = 0;
        apart = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY === 1'b1) nack++;
            if (S_AXI_AWREADY !== S_AXI_WREADY) apart = 1;
        end
        checks++;
        if (nack != 1 || apart) begin
            errors++;
            $display("FAIL aw_early_ack: cycles %0d split %0d required 1 0", nack, apart);
        end
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        wait_b(resp, pulse);
        mdl[1] = d;
        checks++;
        if (reg_q[1] !== mdl[1] || resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL aw_early_val: got %h %b required %h 00", reg_q[1], resp, mdl[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] d1, d2;
        bit got;
        d1 = $urandom;
        d2 = $urandom;
        S_AXI_AWADDR = AW'(8);
        S_AXI_WDATA = d1;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin
                got = 1;
                break;
            end
        end
        @(posedge ACLK);
        #1;
        S_AXI_AWADDR = AW'(12);
        S_AXI_WDATA = d2;
        mdl[2] = d1;
        @(negedge ACLK);
        checks++;
        if (!got || S_AXI_BVALID !== 1'b1 || reg_wr_pulse !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_first: bvalid %b pulse %b required 1 0100", S_AXI_BVALID, reg_wr_pulse);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge ACLK);
            checks++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold%0d: bvalid %b awready %b required 1 0",
                         i, S_AXI_BVALID, S_AXI_AWREADY);
            end
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_second: AWREADY never rose, required 1");
        end
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        wait_b(resp, pulse);
        mdl[3] = d2;
        checks++;
        if (reg_q[2] !== mdl[2] || reg_q[3] !== mdl[3] || pulse !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_vals: r2 %h r3 %h pulse %b required %h %h 1000",
                     reg_q[2], reg_q[3], pulse, mdl[2], mdl[3]);
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] old, d, rd;
        bit got, both;
        old = mdl[3];
        d = $urandom;
        S_AXI_AWADDR = AW'(12);
        S_AXI_ARADDR = AW'(12);
        S_AXI_WDATA = d;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        S_AXI_ARVALID = 1'b1;
        got = 0;
        both = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin
                got = 1;
                both = S_AXI_ARREADY;
                break;
            end
        end
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        rd = S_AXI_RDATA;
        checks++;
        if (!got || !both || S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL conc_hs: ack %0d joint %0d bvalid %b rvalid %b required 1 1 1 1",
                     got, both, S_AXI_BVALID, S_AXI_RVALID);
        end
        checks++;
        if (rd !== old) begin
            errors++;
            $display("FAIL conc_old: got %h required %h", rd, old);
        end
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        mdl[3] = d;
        checks++;
        if (reg_q[3] !== mdl[3]) begin
            errors++;
            $display("FAIL conc_new: got %h required %h", reg_q[3], mdl[3]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        logic [31:0] rd;
        bit got;
        S_AXI_AWADDR = AW'(0);
        S_AXI_WDATA = 32'h5;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin
                got = 1;
                break;
            end
            if (S_AXI_AWREADY) begin
                @(posedge ACLK);
                #1;
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID = 1'b0;
            end
        end
        checks++;
        if (!got || reg_q[0] !== 32'h5) begin
            errors++;
            $display("FAIL rstmid_pre: bvalid %0d reg0 %h required 1 00000005", got, reg_q[0]);
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if (S_AXI_BVALID !== 1'b0 || reg_q !== '0) begin
            errors++;
            $display("FAIL rstmid: bvalid %b reg_q %h required 0 0", S_AXI_BVALID, reg_q);
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        got = 0;
        repeat (4) begin
            @(negedge ACLK);
            if (S_AXI_BVALID !== 1'b0) got = 1;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL rstmid_nob: BVALID after reset, required 0");
        end
        @(posedge ACLK);
        #1;
        do_read(AW'(0), rd, resp);
        checks++;
        if (rd !== mdl[0] || resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL rstmid_rd: got %h %b required 0 00", rd, resp);
        end
    endtask

`ifdef NOLINER_AXIL_SLVERR_EN
    task automatic test_slverr();
        logic [1:0] resp;
        logic [3:0] pulse;
        logic [31:0] rd;
        logic [3:0][31:0] before;
        before = reg_q;
        do_write(AW'(6'h10), $urandom, 4'hF, resp, pulse);
        checks++;
        if (resp !== RESP_SLVERR || pulse !== 4'h0 || reg_q !== before) begin
            errors++;
            $display("FAIL slverr_wr: resp %b pulse %b required 10 0000", resp, pulse);
        end
        do_read(AW'(6'h14), rd, resp);
        checks++;
        if (resp !== RESP_SLVERR || rd !== 32'h0) begin
            errors++;
            $display("FAIL slverr_rd: data %h resp %b required 0 10", rd, resp);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_strobe();
        test_wstrb_zero();
        test_aw_early();
        test_back_to_back();
        test_concurrent();
        test_random();
`ifdef NOLINER_AXIL_SLVERR_EN
        test_slverr();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
